rpn_op_sequencer: RTL and testbench

RPN_OP_SEQUENCER -- requirements
Module: rpn_op_sequencer

---
 rtl/rpn_op_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_rpn_op_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_op_sequencer.sv
// rpn_op_sequencer: sequences one RPN operator against an external stack.
// On the rising edge of is_op it checks the opcode and stack depth, pops the
// operand(s), computes the result, pushes it back and reports completion or
// an error code.
module rpn_op_sequencer #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_is_op,
  input  logic [3:0]        i_op,
  input  logic [CNT_W-1:0]  i_depth,
  output logic              o_pop_req,
  input  logic [DATA_W-1:0] i_pop_data,
  output logic              o_push_req,
  output logic [DATA_W-1:0] o_push_data,
  output logic              o_busy,
  output logic              o_ans_ready,
  output logic              o_print_ready,
  output logic [DATA_W-1:0] o_print_data,
  output logic              o_err,
  output logic [1:0]        o_err_code,
  output logic [3:0]        o_state
);

  // Stack handshake: the stack has no ready/valid back-pressure.
  // o_pop_req is a one-cycle strobe; i_pop_data is valid in the cycle right
  // after the strobe. o_push_req is a one-cycle strobe and o_push_data is valid
  // in that same cycle. Pop and push strobes are never issued together.

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_POP_B  = 4'd1,
    S_WAIT_B = 4'd2,
    S_POP_A  = 4'd3,
    S_WAIT_A = 4'd4,
    S_EXEC   = 4'd5,
    S_PUSH   = 4'd6,
    S_REPORT = 4'd7,
    S_ERR    = 4'd8
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_POP = 4'd4;

  localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
  localparam logic [1:0] ERR_DIV_ZERO  = 2'd2;
  localparam logic [1:0] ERR_UNKNOWN   = 2'd3;

  state_t              r_state;
  logic                r_prev_is_op;
  logic [3:0]          r_op;
  logic [DATA_W-1:0]   r_opa;
  logic [DATA_W-1:0]   r_opb;
  logic                r_pop_req;
  logic                r_push_req;
  logic [DATA_W-1:0]   r_push_data;
  logic                r_busy;
  logic                r_ans_ready;
  logic                r_print_ready;
  logic [DATA_W-1:0]   r_print_data;
  logic                r_err;
  logic [1:0]          r_err_code;

  logic                w_start;
  logic                w_op_unknown;
  logic                w_underflow;
  logic                w_div_zero;
  logic [DATA_W-1:0]   w_result;

  assign w_start      = i_is_op & ~r_prev_is_op;
  assign w_op_unknown = (i_op > OP_POP);
  // POP needs one operand on the stack, every arithmetic op needs two.
  assign w_underflow  = (i_op == OP_POP) ? (i_depth == '0)
                                         : (i_depth < CNT_W'(2));
  assign w_div_zero   = (r_op == OP_DIV) && (r_opb == '0);

  // Unsigned ALU on the latched operands; every result wraps to DATA_W bits.
  always_comb begin
    w_result = '0;
    case (r_op)
      OP_ADD:  w_result = r_opa + r_opb;
      OP_SUB:  w_result = r_opa - r_opb;
      OP_MUL:  w_result = r_opa * r_opb;
      OP_DIV:  w_result = (r_opb == '0) ? '0 : (r_opa / r_opb);
      default: w_result = '0;
    endcase
  end

  // Sequencer FSM; each output register is set on entry to the state that owns it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_prev_is_op  <= 1'b0;
      r_op          <= '0;
      r_opa         <= '0;
      r_opb         <= '0;
      r_pop_req     <= 1'b0;
      r_push_req    <= 1'b0;
      r_push_data   <= '0;
      r_busy        <= 1'b0;
      r_ans_ready   <= 1'b0;
      r_print_ready <= 1'b0;
      r_print_data  <= '0;
      r_err         <= 1'b0;
      r_err_code    <= '0;
    end else begin
      r_prev_is_op  <= i_is_op;
      r_pop_req     <= 1'b0;
      r_push_req    <= 1'b0;
      r_ans_ready   <= 1'b0;
      r_print_ready <= 1'b0;
      r_err         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_op   <= i_op;
            r_busy <= 1'b1;
            if (w_op_unknown) begin
              r_state    <= S_ERR;
              r_err      <= 1'b1;
              r_err_code <= ERR_UNKNOWN;
            end else if (w_underflow) begin
              r_state    <= S_ERR;
              r_err      <= 1'b1;
              r_err_code <= ERR_UNDERFLOW;
            end else begin
              r_state   <= S_POP_B;
              r_pop_req <= 1'b1;
            end
          end
        end
        S_POP_B: begin
          r_state <= S_WAIT_B;
        end
        S_WAIT_B: begin
          r_opb <= i_pop_data;
          if (r_op == OP_POP) begin
            r_state       <= S_REPORT;
            r_ans_ready   <= 1'b1;
            r_print_ready <= 1'b1;
            r_print_data  <= i_pop_data;
          end else begin
            r_state   <= S_POP_A;
            r_pop_req <= 1'b1;
          end
        end
        S_POP_A: begin
          r_state <= S_WAIT_A;
        end
        S_WAIT_A: begin
          r_opa   <= i_pop_data;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          // A zero divisor still consumes both operands; nothing goes back.
          if (w_div_zero) begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_err_code <= ERR_DIV_ZERO;
          end else begin
            r_state     <= S_PUSH;
            r_push_req  <= 1'b1;
            r_push_data <= w_result;
          end
        end
        S_PUSH: begin
          r_state     <= S_REPORT;
          r_ans_ready <= 1'b1;
        end
        S_REPORT: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        S_ERR: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_pop_req     = r_pop_req;
  assign o_push_req    = r_push_req;
  assign o_push_data   = r_push_data;
  assign o_busy        = r_busy;
  assign o_ans_ready   = r_ans_ready;
  assign o_print_ready = r_print_ready;
  assign o_print_data  = r_print_data;
  assign o_err         = r_err;
  assign o_err_code    = r_err_code;
  assign o_state       = r_state;

endmodule

// File: tb/tb_rpn_op_sequencer.sv
// Testbench for rpn_op_sequencer: the bench plays the external stack, drives
// directed and random operators and checks every cycle of each operation
// against a reference model working on a plain queue of values.
module tb_rpn_op_sequencer;

  localparam int DW = 16;
  localparam int CW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          is_op;
  logic [3:0]    op;
  logic [CW-1:0] depth;
  logic          pop_req;
  logic [DW-1:0] pop_data;
  logic          push_req;
  logic [DW-1:0] push_data;
  logic          busy;
  logic          ans_ready;
  logic          print_ready;
  logic [DW-1:0] print_data;
  logic          err;
  logic [1:0]    err_code;
  logic [3:0]    dbg_state;

  rpn_op_sequencer #(.DATA_W(DW), .CNT_W(CW)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_is_op       (is_op),
    .i_op          (op),
    .i_depth       (depth),
    .o_pop_req     (pop_req),
    .i_pop_data    (pop_data),
    .o_push_req    (push_req),
    .o_push_data   (push_data),
    .o_busy        (busy),
    .o_ans_ready   (ans_ready),
    .o_print_ready (print_ready),
    .o_print_data  (print_data),
    .o_err         (err),
    .o_err_code    (err_code),
    .o_state       (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] stk[$];      // stack as seen by the DUT (index 0 = top)
  logic [DW-1:0] ref_stk[$];  // reference model stack
  logic [DW-1:0] exp_q[$];    // expected push values, in order
  logic [DW-1:0] last_print;
  logic [1:0]    last_code;
  logic          last_pop;
  int            n_cmp;
  int            n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One cycle step: at the falling edge, act as the stack for this cycle's requests.
  task automatic tick();
    @(negedge clk);
    if (pop_req) begin
      if (stk.size() > 0) pop_data = stk.pop_front();
      else begin
        chk("stack_underflow", 32'd1, 32'd0);
        pop_data = DW'($urandom);
      end
    end else if (!last_pop) begin
      pop_data = DW'($urandom);
    end
    last_pop = pop_req;
    if (push_req) stk.push_front(push_data);
    depth = CW'(stk.size());
  endtask

  task automatic clear_stack();
    stk.delete();
    ref_stk.delete();
    depth = '0;
  endtask

  task automatic push_val(input logic [DW-1:0] v);
    stk.push_front(v);
    ref_stk.push_front(v);
    depth = CW'(stk.size());
  endtask

  function automatic logic [DW-1:0] rnd_val();
    if ($urandom_range(0, 3) == 0) return DW'($urandom_range(0, 3));
    return DW'($urandom);
  endfunction

  task automatic check_reset_outputs(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_pulses", {pop_req, push_req, ans_ready, print_ready, err}, 0);
      chk("rst_push_data", push_data, 0);
      chk("rst_print_data", print_data, 0);
      chk("rst_err_code", err_code, 0);
    end
  endtask

  // Launch one operator and check 12 cycles of outputs against the model.
  // mode 0: single-cycle is_op; 1: held high, dropped and re-raised while busy;
  // 2: random is_op levels while busy.
  task automatic run_op(input logic [3:0] o, input int mode, input bit rel_rst);
    logic [15:0] ob_pop, ob_push, ob_ans, ob_prt, ob_err;
    logic [15:0] ex_pop, ex_push, ex_ans, ex_prt, ex_err;
    logic [DW-1:0] a, b, r, e;
    logic [2*DW-1:0] prod;
    int done;
    int need;
    bit same;
    ob_pop = 0; ob_push = 0; ob_ans = 0; ob_prt = 0; ob_err = 0;
    ex_pop = 0; ex_push = 0; ex_ans = 0; ex_prt = 0; ex_err = 0;
    need = (o == 4'd4) ? 1 : 2;
    // reference model: decide the outcome from the operator rules
    if (o > 4'd4) begin
      last_code = 2'd3; ex_err[1] = 1'b1; done = 1;
    end else if (ref_stk.size() < need) begin
      last_code = 2'd1; ex_err[1] = 1'b1; done = 1;
    end else if (o == 4'd4) begin
      b = ref_stk.pop_front();
      last_print = b;
      ex_pop[1] = 1'b1; ex_ans[3] = 1'b1; ex_prt[3] = 1'b1; done = 3;
    end else begin
      b = ref_stk.pop_front();
      a = ref_stk.pop_front();
      ex_pop[1] = 1'b1; ex_pop[3] = 1'b1;
      if (o == 4'd3 && b == 0) begin
        last_code = 2'd2; ex_err[6] = 1'b1; done = 6;
      end else begin
        case (o)
          4'd0: r = a + b;
          4'd1: r = a - b;
          4'd2: begin prod = a * b; r = prod[DW-1:0]; end
          default: r = a / b;
        endcase
        ref_stk.push_front(r);
        exp_q.push_back(r);
        ex_push[6] = 1'b1; ex_ans[7] = 1'b1; done = 7;
      end
    end

    tick();
    is_op = 1'b1;
    op = o;
    if (rel_rst) rst = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      tick();
      ob_pop[j] = pop_req;
      ob_push[j] = push_req;
      ob_ans[j] = ans_ready;
      ob_prt[j] = print_ready;
      ob_err[j] = err;
      chk("busy", busy, (j <= done) ? 1 : 0);
      if (push_req) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("push_data", push_data, e);
        end else chk("push_unexpected", 32'd1, 32'd0);
      end
      if (print_ready) chk("print_data", print_data, last_print);
      if (err) chk("err_code", err_code, last_code);
      if (mode == 0) is_op = 1'b0;
      else if (j <= done) begin
        if (mode == 2) is_op = 1'($urandom_range(0, 1));
        else if (j == 5) is_op = 1'b0;
        else if (j == 6) is_op = 1'b1;
      end
    end
    chk("pop_cycles", ob_pop, ex_pop);
    chk("push_cycles", ob_push, ex_push);
    chk("ans_cycles", ob_ans, ex_ans);
    chk("print_cycles", ob_prt, ex_prt);
    chk("err_cycles", ob_err, ex_err);
    chk("err_code_held", err_code, last_code);
    chk("print_data_held", print_data, last_print);
    chk("stack_size", stk.size(), ref_stk.size());
    same = 1'b1;
    if (stk.size() == ref_stk.size())
      for (int i = 0; i < ref_stk.size(); i++) if (stk[i] !== ref_stk[i]) same = 1'b0;
    chk("stack_data", same, 1);
    tick();
    is_op = 1'b0;
    tick();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_cmp = 0; n_bad = 0;
    last_print = '0; last_code = '0; last_pop = 1'b0;
    rst = 1'b1; is_op = 1'b0; op = '0; pop_data = '0; depth = '0;

    check_reset_outputs(3);
    tick();
    rst = 1'b0;
    tick();

    // directed cases
    clear_stack(); push_val(16'd5); push_val(16'd3);
    run_op(4'd0, 0, 1'b0);
    chk("add_3_5", stk[0], 16'd8);

    clear_stack(); push_val(16'd2); push_val(16'd7);
    run_op(4'd1, 0, 1'b0);
    chk("sub_2_7", stk[0], 16'hFFFB);

    clear_stack(); push_val(16'd9); push_val(16'd0);
    run_op(4'd3, 0, 1'b0);
    chk("div0_code", err_code, 2);
    chk("div0_stack_empty", stk.size(), 0);

    clear_stack(); push_val(16'd4);
    run_op(4'd2, 0, 1'b0);
    chk("mul_depth1_code", err_code, 1);

    clear_stack(); push_val(16'd42);
    run_op(4'd4, 0, 1'b0);
    chk("pop_42", print_data, 16'd42);

    clear_stack(); push_val(16'd5); push_val(16'd3);
    run_op(4'd0, 1, 1'b0);

    clear_stack(); push_val(16'd1); push_val(16'd2);
    run_op(4'd9, 0, 1'b0);
    chk("unknown_code", err_code, 3);

    clear_stack();
    run_op(4'd4, 0, 1'b0);

    clear_stack(); push_val(16'd100); push_val(16'd3);
    run_op(4'd3, 2, 1'b0);
    chk("div_100_3", stk[0], 16'd33);

    clear_stack(); push_val(16'h1234); push_val(16'h0100);
    run_op(4'd2, 0, 1'b0);
    chk("mul_wrap", stk[0], 16'h3400);

    // random operators against the model
    clear_stack();
    for (int n = 0; n < 60; n++) begin
      logic [3:0] o;
      if (stk.size() < 3 || $urandom_range(0, 4) == 0) begin
        int k;
        k = $urandom_range(0, 4);
        for (int i = 0; i < k; i++) if (stk.size() < 20) push_val(rnd_val());
      end
      if ($urandom_range(0, 9) == 0) o = 4'($urandom_range(5, 15));
      else o = 4'($urandom_range(0, 4));
      run_op(o, $urandom_range(0, 2), 1'b0);
    end

    // reset in the middle of an ADD, then is_op high in the first cycle after reset
    clear_stack(); push_val(16'd33); push_val(16'd22); push_val(16'd11);
    tick();
    is_op = 1'b1; op = 4'd0;
    tick();
    chk("abort_first_pop", pop_req, 1);
    void'(ref_stk.pop_front());
    tick();
    rst = 1'b1;
    check_reset_outputs(3);
    last_print = '0; last_code = '0;
    chk("abort_stack_size", stk.size(), ref_stk.size());
    run_op(4'd4, 0, 1'b1);
    chk("after_reset_pop", print_data, 16'd22);

    chk("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
